// File: rtl/peripheral_operand_sequencer.sv
// Front-panel sequencer: collects operands A/B and an opcode one byte per enter press,
// starts the ALU, waits for done with a timeout, and holds the result until the next press.
module peripheral_operand_sequencer #(
    parameter int NBYTES  = 4,
    parameter int OPW     = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [7:0]                inputdata,
    input  logic                      enterkey,
    input  logic                      cancel,
    input  logic                      alu_done,
    input  logic [8*NBYTES-1:0]       alu_result,
    output logic [8*NBYTES-1:0]       dataA,
    output logic [8*NBYTES-1:0]       dataB,
    output logic [OPW-1:0]            opcode,
    output logic                      alu_start,
    output logic [8*NBYTES-1:0]       result,
    output logic                      result_valid,
    output logic                      error,
    output logic [2:0]                stage,
    output logic [$clog2(NBYTES)-1:0] byte_idx
);
    localparam int DW  = 8 * NBYTES;
    localparam int BIW = $clog2(NBYTES);
    localparam int CW  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        LOADA  = 3'd0,
        LOADB  = 3'd1,
        LOADOP = 3'd2,
        START  = 3'd3,
        WAIT   = 3'd4,
        SHOW   = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic           enter_q;
    logic           enter_evt;
    logic           clr;
    logic [DW-1:0]  data_a_q, data_a_d;
    logic [DW-1:0]  data_b_q, data_b_d;
    logic [OPW-1:0] op_q, op_d;
    logic [DW-1:0]  res_q, res_d;
    logic           vld_q, vld_d;
    logic           err_q, err_d;
    logic           start_q, start_d;
    logic [BIW-1:0] idx_q, idx_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    always_comb begin
        enter_evt = enterkey & ~enter_q;
        clr       = 1'b0;
        state_d   = state_q;
        data_a_d  = data_a_q;
        data_b_d  = data_b_q;
        op_d      = op_q;
        res_d     = res_q;
        vld_d     = vld_q;
        err_d     = err_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        start_d   = 1'b0;
        case (state_q)
            LOADA, LOADB: begin
                if (cancel) begin
                    clr = 1'b1;
                end else if (enter_evt) begin
                    if (state_q == LOADA) data_a_d[8*idx_q +: 8] = inputdata;
                    else                  data_b_d[8*idx_q +: 8] = inputdata;
                    if (idx_q == BIW'(NBYTES - 1)) begin
                        idx_d = '0;
                        if (state_q == LOADA) state_d = LOADB;
                        else                  state_d = LOADOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            LOADOP: begin
                if (cancel) begin
                    clr = 1'b1;
                end else if (enter_evt) begin
                    op_d    = inputdata[OPW-1:0];
                    state_d = START;
                    start_d = 1'b1;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // done is checked first so a completion on the last allowed cycle still counts
                if (alu_done) begin
                    res_d   = alu_result;
                    vld_d   = 1'b1;
                    state_d = SHOW;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    res_d   = '0;
                    state_d = SHOW;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHOW: begin
                if (cancel || enter_evt) clr = 1'b1;
            end
            default: state_d = LOADA;
        endcase
        if (clr) begin
            state_d  = LOADA;
            data_a_d = '0;
            data_b_d = '0;
            op_d     = '0;
            res_d    = '0;
            vld_d    = 1'b0;
            err_d    = 1'b0;
            idx_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= LOADA;
            enter_q  <= 1'b1;
            data_a_q <= '0;
            data_b_q <= '0;
            op_q     <= '0;
            res_q    <= '0;
            vld_q    <= 1'b0;
            err_q    <= 1'b0;
            start_q  <= 1'b0;
            idx_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            enter_q  <= enterkey;
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
            op_q     <= op_d;
            res_q    <= res_d;
            vld_q    <= vld_d;
            err_q    <= err_d;
            start_q  <= start_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
        end
    end

    assign dataA        = data_a_q;
    assign dataB        = data_b_q;
    assign opcode       = op_q;
    assign alu_start    = start_q;
    assign result       = res_q;
    assign result_valid = vld_q;
    assign error        = err_q;
    assign stage        = state_q;
    assign byte_idx     = idx_q;

endmodule
